// File: rtl/adc_disp_pkg.sv
// Shared types, sizing constants and helpers for the ADC-code to BCD display path.
package adc_disp_pkg;

    localparam int unsigned CODE_W   = 16;
    localparam int unsigned ACC_W    = 30;
    localparam int unsigned BCD_W    = 16;
    localparam int unsigned MV_MAX   = 9999;
    localparam int unsigned ITER     = 16;
    localparam int unsigned MV_SHIFT = 15;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StBcd,
        StDone
    } state_e;

    // Double-dabble correction applied before every left shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Accumulator holds code * FSR_MV; dropping 15 bits yields truncated millivolts.
    function automatic logic [BCD_W-1:0] scale_mv(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] s;
        s = acc >> MV_SHIFT;
        if (s > ACC_W'(MV_MAX)) begin
            return BCD_W'(MV_MAX);
        end
        return s[BCD_W-1:0];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: loads on start, then performs one shift per cycle for ITER cycles.
module bin2bcd_seq
    import adc_disp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BCD_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BCD_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [3:0]       cnt_q;
    logic             busy_q;
    logic             done_q;

    assign bcd_adj = bcd_adjust(bcd_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            // Top bit of the adjusted value is always zero for inputs up to 9999.
            bcd_q <= BCD_W'({bcd_adj, bin_q[BCD_W-1]});
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'(ITER - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/adc_code_to_bcd.sv
// ADS1115 conversion word -> millivolts -> four held BCD digits (digit3 = thousands).
// Define ADC_BCD_SIGNED_EN to display negative codes by magnitude with a neg flag.
module adc_code_to_bcd
    import adc_disp_pkg::*;
#(
    parameter int unsigned FSR_MV = 4096,
    parameter int unsigned CODE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic              out_valid,
    output logic [3:0]        digit3,
    output logic [3:0]        digit2,
    output logic [3:0]        digit1,
    output logic [3:0]        digit0,
    output logic              neg,
    output logic              overrun
);

    localparam logic [ACC_W-1:0] FsrAcc = ACC_W'(FSR_MV);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [CODE_W-1:0] mag_q;
    logic [CODE_W-1:0] mag_in;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [BCD_W-1:0]  digits_q;
    logic              neg_q;
    logic              out_valid_q;
    logic              overrun_q;

    logic              bcd_start;
    logic [BCD_W-1:0]  bcd_bin;
    logic              bcd_done;
    logic [BCD_W-1:0]  bcd_val;

`ifdef ADC_BCD_SIGNED_EN
    logic sign_q;
    // Negation kept CODE_W wide: 0x8000 maps onto itself, i.e. magnitude 32768.
    assign mag_in = in_code[CODE_W-1] ? (~in_code + 1'b1) : in_code;
`else
    assign mag_in = in_code[CODE_W-1] ? '0 : in_code;
`endif

    always_comb begin
        acc_d = acc_q;
        if (mag_q[cnt_q]) begin
            acc_d = acc_q + (FsrAcc << cnt_q);
        end
    end

    // Kick the BCD engine on the edge that folds in the last partial product.
    assign bcd_start = (state_q == StMult) && (cnt_q == 4'(ITER - 1));
    assign bcd_bin   = scale_mv(acc_d);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (bcd_start),
        .bin   (bcd_bin),
        .done  (bcd_done),
        .bcd   (bcd_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mag_q       <= '0;
            acc_q       <= '0;
            digits_q    <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef ADC_BCD_SIGNED_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            overrun_q   <= in_valid && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mag_q   <= mag_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StMult;
`ifdef ADC_BCD_SIGNED_EN
                        sign_q  <= in_code[CODE_W-1];
`endif
                    end
                end
                StMult: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(ITER - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StBcd;
                    end
                end
                StBcd: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(ITER - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bcd_done) begin
                        digits_q    <= bcd_val;
                        out_valid_q <= 1'b1;
`ifdef ADC_BCD_SIGNED_EN
                        // A negative code that truncates to 0 mV shows as plain 0000.
                        neg_q       <= sign_q && (scale_mv(acc_q) != '0);
`else
                        neg_q       <= 1'b0;
`endif
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign digit3    = digits_q[15:12];
    assign digit2    = digits_q[11:8];
    assign digit1    = digits_q[7:4];
    assign digit0    = digits_q[3:0];
    assign neg       = neg_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_code_to_bcd.sv
// Scoreboard bench for adc_code_to_bcd: two instances (FSR 4096 mV and 9999 mV).
module tb_adc_code_to_bcd;

    typedef struct {
        logic [15:0] digits;
        logic        neg;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid0, in_valid1;
    logic [15:0] in_code0, in_code1;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [3:0]  d3_0, d2_0, d1_0, d0_0;
    logic [3:0]  d3_1, d2_1, d1_1, d0_1;
    logic        neg0, neg1;
    logic        overrun0, overrun1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   ovr0    = 0;
    int   ovr1    = 0;
    int   ov0     = 0;

    always #5 clk = ~clk;

    adc_code_to_bcd #(.FSR_MV(4096), .CODE_W(16)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid0),
        .in_code   (in_code0),
        .in_ready  (in_ready0),
        .out_valid (out_valid0),
        .digit3    (d3_0),
        .digit2    (d2_0),
        .digit1    (d1_0),
        .digit0    (d0_0),
        .neg       (neg0),
        .overrun   (overrun0)
    );

    adc_code_to_bcd #(.FSR_MV(9999), .CODE_W(16)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_code   (in_code1),
        .in_ready  (in_ready1),
        .out_valid (out_valid1),
        .digit3    (d3_1),
        .digit2    (d2_1),
        .digit1    (d1_1),
        .digit0    (d0_1),
        .neg       (neg1),
        .overrun   (overrun1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (overrun0) ovr0++;
        if (out_valid0) begin
            ov0++;
            if (q0.size() == 0) begin
                check("dut0 unexpected out_valid", 1, 0);
            end else begin
                e = q0.pop_front();
                check("dut0 digits", {d3_0, d2_0, d1_0, d0_0}, e.digits);
                check("dut0 neg", neg0, e.neg);
                check("dut0 latency cycle", cyc, e.due);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (overrun1) ovr1++;
        if (out_valid1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected out_valid", 1, 0);
            end else begin
                e = q1.pop_front();
                check("dut1 digits", {d3_1, d2_1, d1_1, d0_1}, e.digits);
                check("dut1 neg", neg1, e.neg);
                check("dut1 latency cycle", cyc, e.due);
            end
        end
    end

    // Called at a negedge; waits (bounded) for in_ready, issues a one-cycle strobe.
    task automatic strobe(input bit which, input logic [15:0] code, input logic [15:0] dig,
                          input logic ng);
        exp_t e;
        int   t;
        t = 0;
        while (((which ? in_ready1 : in_ready0) == 1'b0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("in_ready wait timeout", 0, 1);
        e.digits = dig;
        e.neg    = ng;
        e.due    = cyc + 34;
        if (which) begin
            in_code1  = code;
            in_valid1 = 1'b1;
            q1.push_back(e);
        end else begin
            in_code0  = code;
            in_valid0 = 1'b1;
            q0.push_back(e);
        end
        @(negedge clk);
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() + q1.size()) != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            check("out_valid wait timeout", q0.size() + q1.size(), 0);
            q0.delete();
            q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_before;
        int ovr_before;
        reset     = 1'b1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_code0  = '0;
        in_code1  = '0;
        repeat (3) @(negedge clk);

        check("reset in_ready", in_ready0, 1);
        check("reset out_valid", out_valid0, 0);
        check("reset digits", {d3_0, d2_0, d1_0, d0_0}, 0);
        check("reset neg", neg0, 0);
        check("reset overrun", overrun0, 0);
        reset = 1'b0;
        @(negedge clk);

        strobe(1'b0, 16'h7FFF, 16'h4095, 1'b0);
        drain();
        repeat (10) @(negedge clk);
        check("digits held", {d3_0, d2_0, d1_0, d0_0}, 16'h4095);

        strobe(1'b0, 16'h4000, 16'h2048, 1'b0);
        drain();
        strobe(1'b0, 16'h0001, 16'h0000, 1'b0);
        drain();
`ifdef ADC_BCD_SIGNED_EN
        strobe(1'b0, 16'h8000, 16'h4096, 1'b1);
        drain();
        strobe(1'b0, 16'hC000, 16'h2048, 1'b1);
        drain();
`else
        strobe(1'b0, 16'h8000, 16'h0000, 1'b0);
        drain();
        strobe(1'b0, 16'hC000, 16'h0000, 1'b0);
        drain();
`endif
        strobe(1'b0, 16'hFFFF, 16'h0000, 1'b0);
        drain();

        // Second strobe while busy must be dropped and flagged once.
        ovr_before = ovr0;
        strobe(1'b0, 16'h2000, 16'h1024, 1'b0);
        repeat (4) @(negedge clk);
        check("in_ready low while busy", in_ready0, 0);
        in_code0  = 16'h7FFF;
        in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        check("overrun pulse count", ovr0 - ovr_before, 1);
        check("digits after overrun", {d3_0, d2_0, d1_0, d0_0}, 16'h1024);

        // Abort mid-conversion; a strobe coinciding with reset is also dropped.
        ov_before = ov0;
        in_code0  = 16'h7FFF;
        in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        repeat (18) @(negedge clk);
        reset     = 1'b1;
        in_code0  = 16'h4000;
        in_valid0 = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        in_valid0 = 1'b0;
        check("in_ready after reset", in_ready0, 1);
        check("digits after reset", {d3_0, d2_0, d1_0, d0_0}, 0);
        check("out_valid after reset", out_valid0, 0);
        repeat (50) @(negedge clk);
        check("no out_valid after abort", ov0 - ov_before, 0);
        check("in_ready idle after abort", in_ready0, 1);

        strobe(1'b1, 16'h7FFF, 16'h9998, 1'b0);
        drain();
        strobe(1'b1, 16'h4000, 16'h4999, 1'b0);
        drain();
        check("dut1 overrun count", ovr1, 0);
        check("scoreboard empty", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
